// File: rtl/byte_unstriping.sv
// Byte unstriping: merges two striped 32-bit lanes back into one ordered
// stream (lane 0, lane 1, lane 0, ...) using a small FIFO per lane.
module byte_unstriping #(
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic [31:0] lane_0,
  input  logic        valid_0,
  input  logic [31:0] lane_1,
  input  logic        valid_1,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active,
  output logic        overflow_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic [CW-1:0] LP_FULL    = CW'(FIFO_DEPTH);
  localparam logic [7:0]    LP_TIMEOUT = 8'(IDLE_TIMEOUT);

  logic [31:0]   r_mem0 [FIFO_DEPTH];
  logic [31:0]   r_mem1 [FIFO_DEPTH];
  logic [PW-1:0] r_wp0, r_rp0, r_wp1, r_rp1;
  logic [CW-1:0] r_cnt0, r_cnt1;
  logic [1:0]    r_state;
  logic          r_sel;
  logic [7:0]    r_idleCnt;
  logic [31:0]   r_dataOut;
  logic          r_validOut;
  logic          r_active;
  logic          r_overflow;

  logic          w_empty0, w_empty1, w_full0, w_full1;
  logic          w_want0, w_want1, w_pop0, w_pop1;
  logic          w_push0, w_push1, w_ovf;
  logic          w_quiet, w_timeout;
  logic [7:0]    w_idleInc;

  // Decide this edge's pushes, pops, overflow and timeout from current state
  always_comb begin
    w_empty0  = (r_cnt0 == '0);
    w_empty1  = (r_cnt1 == '0);
    w_full0   = (r_cnt0 == LP_FULL);
    w_full1   = (r_cnt1 == LP_FULL);
    w_pop0    = (r_state == ST_RUN) && !r_sel && !w_empty0;
    w_pop1    = (r_state == ST_RUN) &&  r_sel && !w_empty1;
    w_want0   = ((r_state == ST_IDLE) || (r_state == ST_RUN)) && valid_0;
    w_want1   = ((r_state == ST_IDLE) && valid_0 && valid_1) ||
                ((r_state == ST_RUN) && valid_1);
    w_push0   = w_want0 && (!w_full0 || w_pop0);
    w_push1   = w_want1 && (!w_full1 || w_pop1);
    w_ovf     = (w_want0 && !w_push0) || (w_want1 && !w_push1);
    w_quiet   = (r_state == ST_RUN) && w_empty0 && w_empty1 && !valid_0 && !valid_1;
    w_idleInc = r_idleCnt + 8'd1;
    w_timeout = w_quiet && (w_idleInc == LP_TIMEOUT);
  end

  // Lane storage; nothing is written on a reset edge
  always_ff @(posedge clk_2f) begin
    if (!reset && w_push0) r_mem0[r_wp0] <= lane_0;
    if (!reset && w_push1) r_mem1[r_wp1] <= lane_1;
  end

  // Pointers, counts, output register, lane select, idle counter and FSM
  always_ff @(posedge clk_2f) begin
    if (reset) begin
      r_wp0      <= '0;
      r_rp0      <= '0;
      r_wp1      <= '0;
      r_rp1      <= '0;
      r_cnt0     <= '0;
      r_cnt1     <= '0;
      r_state    <= ST_IDLE;
      r_sel      <= 1'b0;
      r_idleCnt  <= 8'd0;
      r_dataOut  <= 32'h0;
      r_validOut <= 1'b0;
      r_active   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push0) r_wp0 <= r_wp0 + PW'(1);
      if (w_pop0)  r_rp0 <= r_rp0 + PW'(1);
      if (w_push1) r_wp1 <= r_wp1 + PW'(1);
      if (w_pop1)  r_rp1 <= r_rp1 + PW'(1);
      r_cnt0 <= r_cnt0 + CW'(w_push0) - CW'(w_pop0);
      r_cnt1 <= r_cnt1 + CW'(w_push1) - CW'(w_pop1);

      if (w_pop0) begin
        r_dataOut  <= r_mem0[r_rp0];
        r_validOut <= 1'b1;
      end else if (w_pop1) begin
        r_dataOut  <= r_mem1[r_rp1];
        r_validOut <= 1'b1;
      end else begin
        r_dataOut  <= 32'h0;
        r_validOut <= 1'b0;
      end

      if (w_ovf) r_overflow <= 1'b1;

      if (valid_0 || valid_1)  r_idleCnt <= 8'd0;
      else if (w_timeout)      r_idleCnt <= 8'd0;
      else if (w_quiet)        r_idleCnt <= w_idleInc;

      case (r_state)
        ST_IDLE: begin
          r_sel <= 1'b0;
          if (valid_0) begin
            r_state  <= ST_RUN;
            r_active <= 1'b1;
          end
        end
        ST_RUN: begin
          if (w_ovf) begin
            r_state  <= ST_ERR;
            r_active <= 1'b0;
          end else if (w_timeout) begin
            r_state  <= ST_IDLE;
            r_active <= 1'b0;
            r_sel    <= 1'b0;
          end
          if (!w_ovf && !w_timeout && (w_pop0 || w_pop1)) r_sel <= ~r_sel;
          else if (w_ovf && (w_pop0 || w_pop1))          r_sel <= ~r_sel;
        end
        ST_ERR: begin
          r_active <= 1'b0;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign data_out     = r_dataOut;
  assign valid_out    = r_validOut;
  assign active       = r_active;
  assign overflow_err = r_overflow;

endmodule

// File: doc/byte_unstriping.md
BYTE_UNSTRIPING -- requirements
Module: byte_unstriping

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, per-lane buffer depth in 32-bit words, power of 2, minimum 2.
REQ-002 Parameter: IDLE_TIMEOUT, default 8, number of consecutive quiet cycles in RUN before the block returns to IDLE, range 1..255.
REQ-003 One clock, clk_2f; reset is synchronous and active-high.
REQ-004 clk_2f  input  1  sole clock, rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 lane_0  input  32  lane 0 word; carries even-position words of the striped stream.
REQ-007 valid_0  input  1  lane_0 qualifier.
REQ-008 lane_1  input  32  lane 1 word; carries odd-position words.
REQ-009 valid_1  input  1  lane_1 qualifier.
REQ-010 data_out  output  32  reassembled word, registered.
REQ-011 valid_out  output  1  data_out qualifier, registered.
REQ-012 active  output  1  high while the state is RUN.
REQ-013 overflow_err  output  1  sticky lane-FIFO overflow flag.

Function
REQ-014 Purpose: merge the two striped lanes back into one ordered word stream at clk_2f, in the order lane 0, lane 1, lane 0, ...
REQ-015 States: IDLE, RUN and ERR; 2-bit encoded; no other reachable state.
REQ-016 Each lane has an independent FIFO of FIFO_DEPTH words, with a count that runs 0..FIFO_DEPTH.
REQ-017 IDLE: valid_1 words are discarded. A valid_0 word is pushed to FIFO0 and the state moves to RUN on the same edge. If valid_1 is also high on that edge, its word is pushed to FIFO1.
REQ-018 RUN: every cycle with valid_x=1 pushes lane_x into FIFOx.
REQ-019 RUN: a 1-bit sel register selects the lane expected next; sel=0 on entry to RUN.
REQ-020 RUN: if FIFO[sel] is non-empty at an edge, its head is popped, data_out=head, valid_out=1, and sel toggles.
REQ-021 RUN: if FIFO[sel] is empty, valid_out=0, data_out=32'h0 and sel holds. The other lane is never read out of order.
REQ-022 Latency: a word pushed at edge N is output no earlier than edge N+1; there is no bypass path.
REQ-023 Full-FIFO rule: a push into a full FIFO is accepted only if the same FIFO pops on the same edge.
REQ-024 Overflow: any other push into a full FIFO drops the word, sets overflow_err=1 and moves the state to ERR on that edge. A pop scheduled on that edge still completes.
REQ-025 ERR: valid_out=0, data_out=0, inputs ignored, FIFO contents frozen; the block leaves ERR only on reset.
REQ-026 Idle timeout counter: 8 bits; cleared on any cycle with valid_0 or valid_1 high; increments in RUN while both FIFOs are empty and both valids are low.
REQ-027 When the idle timeout counter reaches IDLE_TIMEOUT, the state goes to IDLE, sel is cleared to 0 and the counter is cleared.
REQ-028 active = (state == RUN), registered.
REQ-029 overflow_err is cleared only by reset.

Reset
REQ-030 On reset=1 at an edge: state=IDLE, both FIFOs flushed (counts=0, pointers=0), sel=0, idle timeout counter=0.
REQ-031 On reset=1 at an edge: data_out=32'h0, valid_out=0, active=0, overflow_err=0.
REQ-032 Reset dominates every input, including mid-stream and while in ERR; pushes presented on the reset edge are discarded.
REQ-033 The first cycle after reset deasserts is an ordinary IDLE cycle.

Verification
REQ-034 Alternating input: valid_0 with A0, then valid_1 with A1, then B0 on lane 0, then B1 on lane 1, one per cycle -> data_out sequence A0,A1,B0,B1 on 4 consecutive valid_out cycles, starting 1 edge after A0; active=1.
REQ-035 In IDLE, valid_1=1 with 32'hDEAD_BEEF before any lane 0 word -> word dropped, state stays IDLE; the first output after a later lane-0 word is that lane-0 word.
REQ-036 Skew: 3 lane-0 words arrive before any lane-1 word -> outputs the first lane-0 word, then valid_out=0 until the lane-1 word arrives; strict lane-0/lane-1 alternation is preserved.
REQ-037 Overflow: with FIFO_DEPTH=4 and lane 1 silent, 6 lane-0 words in 6 cycles -> overflow_err=1 on the sixth push; state=ERR; valid_out stays 0 afterwards.
REQ-038 Timeout: after a balanced burst, 8 quiet cycles -> active drops to 0 at the 8th quiet edge; the next valid_1-only word is discarded.
REQ-039 Mid-stream recovery: reset asserted for 1 cycle mid-stream and in ERR -> all outputs 0 the next cycle, overflow_err=0, and a fresh alternating stream reassembles correctly.
